// File: rtl/rv_alu_arb_if.sv
// Bundle of requester, response and ALU-side signals for rv_alu_arb.
// Directional suffixes (_i/_o) are named from the arbiter's point of view.
// Ports: req0/1 valid/ready/operands, rsp0/1 valid/ready/result,
//        alu_op1/op2/op_sel/op_32b toward the ALU, alu_result back.
// The slave modport is the arbiter; master is the issue stage plus ALU.
interface rv_alu_arb_if #(
    parameter int XLEN = 64
);
    logic            req0_valid_i;
    logic            req1_valid_i;
    logic            req0_ready_o;
    logic            req1_ready_o;
    logic [XLEN-1:0] req0_op1_i;
    logic [XLEN-1:0] req0_op2_i;
    logic [XLEN-1:0] req1_op1_i;
    logic [XLEN-1:0] req1_op2_i;
    logic [3:0]      req0_op_sel_i;
    logic [3:0]      req1_op_sel_i;
    logic            req0_op_32b_i;
    logic            req1_op_32b_i;
    logic            rsp0_valid_o;
    logic            rsp1_valid_o;
    logic            rsp0_ready_i;
    logic            rsp1_ready_i;
    logic [XLEN-1:0] rsp0_result_o;
    logic [XLEN-1:0] rsp1_result_o;
    logic [XLEN-1:0] alu_op1_o;
    logic [XLEN-1:0] alu_op2_o;
    logic [3:0]      alu_op_sel_o;
    logic            alu_op_32b_o;
    logic [XLEN-1:0] alu_result_i;

    modport slave (
        input  req0_valid_i, req1_valid_i,
        input  req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i,
        input  req0_op_sel_i, req1_op_sel_i, req0_op_32b_i, req1_op_32b_i,
        input  rsp0_ready_i, rsp1_ready_i, alu_result_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp1_valid_o, rsp0_result_o, rsp1_result_o,
        output alu_op1_o, alu_op2_o, alu_op_sel_o, alu_op_32b_o
    );

    modport master (
        output req0_valid_i, req1_valid_i,
        output req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i,
        output req0_op_sel_i, req1_op_sel_i, req0_op_32b_i, req1_op_32b_i,
        output rsp0_ready_i, rsp1_ready_i, alu_result_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp1_valid_o, rsp0_result_o, rsp1_result_o,
        input  alu_op1_o, alu_op2_o, alu_op_sel_o, alu_op_32b_o
    );
endinterface

// File: rtl/rv_alu_arb.sv
// Round-robin share of one combinational ALU between two requesters.
// Latency: grant in cycle N, registered result valid in cycle N+1.
// Backpressure: a stalled response blocks only its own requester.
// Ports: clk_i, rst_n_i (async active-low), bus (rv_alu_arb_if.slave)
//        carrying both request/response channels and the ALU operand path.
module rv_alu_arb #(
    parameter int XLEN = 64
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    rv_alu_arb_if.slave  bus
);
    logic [1:0]      req_vld;
    logic [1:0]      rsp_rdy;
    logic [1:0]      slot_free;
    logic [1:0]      elig;
    logic [1:0]      grant;

    // prio_q names the requester that wins a tie this cycle.
    logic            prio_q, prio_d;
    logic [1:0]      rsp_vld_q, rsp_vld_d;
    logic [XLEN-1:0] rsp0_res_q, rsp0_res_d;
    logic [XLEN-1:0] rsp1_res_q, rsp1_res_d;

    logic [XLEN-1:0] alu_op1;
    logic [XLEN-1:0] alu_op2;
    logic [3:0]      alu_op_sel;
    logic            alu_op_32b;

    assign req_vld = {bus.req1_valid_i, bus.req0_valid_i};
    assign rsp_rdy = {bus.rsp1_ready_i, bus.rsp0_ready_i};

    // A response slot can take a new result if it is empty or being drained.
    assign slot_free = ~rsp_vld_q | rsp_rdy;
    assign elig      = req_vld & slot_free;

    always_comb begin
        grant = 2'b00;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer moves to the loser after any grant, so contention alternates.
    always_comb begin
        prio_d = prio_q;
        if (grant[0]) begin
            prio_d = 1'b1;
        end else if (grant[1]) begin
            prio_d = 1'b0;
        end
    end

    // Idle ALU inputs are forced to zero rather than left on a stale requester.
    always_comb begin
        alu_op1    = '0;
        alu_op2    = '0;
        alu_op_sel = 4'b0000;
        alu_op_32b = 1'b0;
        if (grant[0]) begin
            alu_op1    = bus.req0_op1_i;
            alu_op2    = bus.req0_op2_i;
            alu_op_sel = bus.req0_op_sel_i;
            alu_op_32b = bus.req0_op_32b_i;
        end else if (grant[1]) begin
            alu_op1    = bus.req1_op1_i;
            alu_op2    = bus.req1_op2_i;
            alu_op_sel = bus.req1_op_sel_i;
            alu_op_32b = bus.req1_op_32b_i;
        end
    end

    // A grant refills the slot even while the old result drains, so a
    // requester can issue back-to-back with valid held continuously high.
    always_comb begin
        rsp_vld_d  = grant | (rsp_vld_q & ~rsp_rdy);
        rsp0_res_d = grant[0] ? bus.alu_result_i : rsp0_res_q;
        rsp1_res_d = grant[1] ? bus.alu_result_i : rsp1_res_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prio_q     <= 1'b0;
            rsp_vld_q  <= 2'b00;
            rsp0_res_q <= '0;
            rsp1_res_q <= '0;
        end else begin
            prio_q     <= prio_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp0_res_q <= rsp0_res_d;
            rsp1_res_q <= rsp1_res_d;
        end
    end

    assign bus.req0_ready_o  = grant[0];
    assign bus.req1_ready_o  = grant[1];
    assign bus.rsp0_valid_o  = rsp_vld_q[0];
    assign bus.rsp1_valid_o  = rsp_vld_q[1];
    assign bus.rsp0_result_o = rsp0_res_q;
    assign bus.rsp1_result_o = rsp1_res_q;
    assign bus.alu_op1_o     = alu_op1;
    assign bus.alu_op2_o     = alu_op2;
    assign bus.alu_op_sel_o  = alu_op_sel;
    assign bus.alu_op_32b_o  = alu_op_32b;
endmodule

// File: doc/rv_alu_arb.md
# rv_alu_arb

Round-robin arbiter that shares the core's single combinational ALU between two requesters (requester 0: integer execute pipe, requester 1: address/branch helper). Each cycle it grants at most one requester, steers that requester's operands to the ALU, and captures the ALU result into a one-entry response register for that requester. It sits between the issue stage and the ALU and owns all ALU operand muxing.

## Interface
- XLEN, 64, operand/result width; must match the ALU's MXLEN.
- clk_i  input  1  clock, all state on rising edge.
- rst_n_i  input  1  asynchronous reset, active-low.
- req0_valid_i / req1_valid_i  input  1  requester k has an operation.
- req0_ready_o / req1_ready_o  output  1  operation of requester k accepted this cycle.
- req0_op1_i, req0_op2_i / req1_op1_i, req1_op2_i  input  XLEN  operands.
- req0_op_sel_i / req1_op_sel_i  input  4  ALU op code: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111.
- req0_op_32b_i / req1_op_32b_i  input  1  32-bit (W) operation.
- rsp0_valid_o / rsp1_valid_o  output  1  response register k holds a result.
- rsp0_ready_i / rsp1_ready_i  input  1  requester k consumes its response.
- rsp0_result_o / rsp1_result_o  output  XLEN  registered result.
- alu_op1_o, alu_op2_o  output  XLEN  operands to ALU.
- alu_op_sel_o  output  4  op code to ALU.
- alu_op_32b_o  output  1  W flag to ALU.
- alu_result_i  input  XLEN  combinational ALU result (already truncated and sign-extended for W ops).

## Operation
- Slot free: slot_free_k = !rsp_k_valid_o || rsp_k_ready_i.
- Eligible: elig_k = req_k_valid_i && slot_free_k.
- Priority pointer prio (1 bit, reset 0) names the preferred requester.
  - Both eligible: grant requester prio.
  - One eligible: grant it.
  - None eligible: no grant.
- After any grant: prio <= index of the requester not granted. No grant: prio holds.
- req_k_ready_o = grant_k (combinational, at most one high). Requesters must not make valid depend on ready.
- ALU steering: on grant, alu_* = granted requester's op1/op2/op_sel/op_32b. With no grant, alu_* = 0.
- Capture at the edge with grant_k: rsp_k_result_o <= alu_result_i and rsp_k_valid_o <= 1.
- Drain: rsp_k_valid_o && rsp_k_ready_i with no new grant_k clears rsp_k_valid_o. With a simultaneous grant_k, valid stays 1 and the result is replaced (back-to-back, one op per cycle per requester).
- rsp_k_result_o holds its value while rsp_k_valid_o = 1 && rsp_k_ready_i = 0.
- Undefined op codes are passed through unchanged. The ALU returns 0 for them, and the block stores 0.

## Timing
- Reset (async, rst_n_i low): rsp0/1_valid_o = 0, rsp0/1_result_o = 0, prio = 0. The ready outputs and alu_* outputs follow from this: ready is 0 if no valid is asserted, and alu_* = 0.
- Reset mid-operation: pending responses are dropped, nothing is replayed, and prio returns to 0.
- Latency: request accepted in cycle N gives rsp valid in cycle N+1 with its result.
- Throughput: one ALU operation per cycle in total.
  - Under continuous contention the grants alternate 0,1,0,1…
  - Worst-case wait for an eligible requester is 1 cycle.
- Backpressure: a stalled response (valid && !ready) blocks only its own requester. The other requester may use the ALU every cycle.
- No combinational path from req_*_valid_i to rsp_*_valid_o.

## Test plan
- Single requester:
  - Stimulus: reset, then req0 add op1=5, op2=7, op_32b=0, held 1 cycle.
  - Required: req0_ready_o = 1 that cycle, alu_op_sel_o = 0000, rsp0_valid_o = 1 next cycle with result 12, and rsp1_valid_o stays 0.
- Contention and fairness:
  - Stimulus: both requesters hold valid for 4 cycles, rsp readies tied high.
  - Required: grants in order 0,1,0,1, each response one cycle after its grant, and never both readies high.
- W op via ALU:
  - Stimulus: req1 add op1 = 0x7FFFFFFF, op2 = 1, op_32b = 1.
  - Required: alu_op_32b_o = 1 during the grant, rsp1_result_o = 0xFFFFFFFF80000000.
- Backpressure isolation:
  - Stimulus: rsp0 full with rsp0_ready_i = 0, both requesters valid for 3 cycles.
  - Required: req0_ready_o stays 0, req1 is granted all 3 cycles, and rsp0_result_o is unchanged.
  - Then raise rsp0_ready_i. Required: req0 is granted in that same cycle.
- Back-to-back drain:
  - Stimulus: req0 streams sub ops (10-3, 20-4, 30-5) with rsp0_ready_i = 1.
  - Required: rsp0_valid_o is continuous for 3 cycles with results 7, 16, 25.
- Reset mid-flight:
  - Stimulus: assert rst_n_i low asynchronously while rsp1_valid_o = 1 and prio = 1.
  - Required: rsp1_valid_o = 0 immediately without a clock edge, results = 0. After release, with both requesters valid, the first grant goes to requester 0.
